// File: rtl/shift_cmd_seq_if.sv
// Command handshake and shift-register drive bundle for shift_cmd_seq.
// master: upstream command source; slave: the sequencer.
interface shift_cmd_seq_if #(
  parameter int DATA_W = 4,
  parameter int LEN_W  = 3
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic [LEN_W-1:0]  cmd_len;
  logic [1:0]        M;
  logic [DATA_W-1:0] D;
  logic              SI;
  logic              busy;
  logic              done;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_len,
    input  cmd_ready, M, D, SI, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_len,
    output cmd_ready, M, D, SI, busy, done
  );
endinterface

// File: rtl/shift_cmd_seq.sv
// Command sequencer feeding a 4-bit shift register: expands one accepted
// command into per-cycle mode/data/serial-in values, then pulses done.
//
// state | meaning
// IDLE  | ready for a command; outputs hold (M=00)
// RUN   | presenting one step of the latched command per cycle
// DONE  | one-cycle done pulse, outputs hold
module shift_cmd_seq #(
  parameter int DATA_W = 4,
  parameter int LEN_W  = 3
) (
  input logic            clk,
  input logic            rst,
  shift_cmd_seq_if.slave bus
);
  localparam logic [1:0] OP_WAIT = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_ROTL = 2'b10;
  localparam logic [1:0] OP_SHR  = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        m_q, m_d;
  logic [DATA_W-1:0] d_q, d_d;
  logic              si_q, si_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              emit;
  logic [1:0]        s_op;
  logic [DATA_W-1:0] s_data;

  // State, latches and registered outputs; reset drops any in-flight command.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= OP_WAIT;
      data_q  <= '0;
      cnt_q   <= '0;
      m_q     <= 2'b00;
      d_q     <= '0;
      si_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      d_q     <= d_d;
      si_q    <= si_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state plus next-cycle outputs; the first step is taken straight
  // from the command inputs so it appears in the cycle after acceptance.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    m_d     = 2'b00;
    d_d     = '0;
    si_d    = 1'b0;
    done_d  = 1'b0;
    emit    = 1'b0;
    s_op    = (state_q == IDLE) ? bus.cmd_op   : op_q;
    s_data  = (state_q == IDLE) ? bus.cmd_data : data_q;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          op_d   = bus.cmd_op;
          data_d = bus.cmd_data;
          if (bus.cmd_op == OP_LOAD) begin
            cnt_d   = LEN_W'(1);
            state_d = RUN;
            emit    = 1'b1;
          end else if (bus.cmd_len == '0) begin
            cnt_d   = '0;
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            cnt_d   = bus.cmd_len;
            state_d = RUN;
            emit    = 1'b1;
          end
        end
      end
      RUN: begin
        if (cnt_q == LEN_W'(1)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
          emit  = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Serial data drains LSB first with zero fill, so long shifts send zeros.
    if (emit) begin
      case (s_op)
        OP_LOAD: begin
          m_d = OP_LOAD;
          d_d = s_data;
        end
        OP_SHR: begin
          m_d    = OP_SHR;
          si_d   = s_data[0];
          data_d = s_data >> 1;
        end
        OP_ROTL: m_d = OP_ROTL;
        default: m_d = 2'b00;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.M         = m_q;
  assign bus.D         = d_q;
  assign bus.SI        = si_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_shift_cmd_seq.sv
// Directed bench for shift_cmd_seq with a behavioural shift_reg4 downstream.
module tb_shift_cmd_seq;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] q;
  int         n_chk  = 0;
  int         n_pass = 0;
  int         n_done = 0;

  shift_cmd_seq_if #(.DATA_W(4), .LEN_W(3)) bus ();

  shift_cmd_seq #(.DATA_W(4), .LEN_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Downstream 4-bit register: SHR enters SI at the MSB, ROTL wraps MSB to LSB.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= 4'b0000;
    else begin
      case (bus.M)
        2'b01:   q <= bus.D;
        2'b11:   q <= {bus.SI, q[3:1]};
        2'b10:   q <= {q[2:0], q[3]};
        default: q <= q;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cmd(input logic [1:0] op, input logic [3:0] data, input logic [2:0] len);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    bus.cmd_len   = len;
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_data  = 4'b0000;
    bus.cmd_len   = 3'd0;

    // reset state
    #12;
    chk("rst_M", bus.M, 2'b00);
    chk("rst_ready", bus.cmd_ready, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    rst = 1'b1;
    tick();

    // 1: LOAD 1101
    cmd(2'b01, 4'b1101, 3'd0);
    tick();
    bus.cmd_valid = 1'b0;
    chk("ld_M", bus.M, 2'b01);
    chk("ld_D", bus.D, 4'b1101);
    chk("ld_ready", bus.cmd_ready, 1'b0);
    chk("ld_busy", bus.busy, 1'b1);
    tick();
    chk("ld_done", bus.done, 1'b1);
    chk("ld_M_hold", bus.M, 2'b00);
    chk("ld_q", q, 4'b1101);
    tick();
    chk("ld_ready_back", bus.cmd_ready, 1'b1);
    chk("ld_done_off", bus.done, 1'b0);

    // 2: SHR len=2 data=xx10; inputs changed after acceptance
    cmd(2'b11, 4'b0010, 3'd2);
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 4'b1111;
    bus.cmd_op    = 2'b01;
    chk("shr_M0", bus.M, 2'b11);
    chk("shr_SI0", bus.SI, 1'b0);
    tick();
    chk("shr_M1", bus.M, 2'b11);
    chk("shr_SI1", bus.SI, 1'b1);
    chk("shr_q1", q, 4'b0110);
    tick();
    chk("shr_done", bus.done, 1'b1);
    chk("shr_q2", q, 4'b1011);
    tick();
    chk("shr_done_off", bus.done, 1'b0);
    chk("shr_ready", bus.cmd_ready, 1'b1);

    // 3: ROTL len=2
    cmd(2'b10, 4'b0000, 3'd2);
    tick();
    bus.cmd_valid = 1'b0;
    chk("rot_M0", bus.M, 2'b10);
    tick();
    chk("rot_M1", bus.M, 2'b10);
    chk("rot_q1", q, 4'b0111);
    tick();
    chk("rot_done", bus.done, 1'b1);
    chk("rot_M_hold", bus.M, 2'b00);
    chk("rot_q2", q, 4'b1110);
    tick();
    tick();
    chk("rot_q_hold", q, 4'b1110);

    // 4: WAIT len=0
    cmd(2'b00, 4'b0000, 3'd0);
    tick();
    bus.cmd_valid = 1'b0;
    chk("w0_done", bus.done, 1'b1);
    chk("w0_M", bus.M, 2'b00);
    chk("w0_ready", bus.cmd_ready, 1'b0);
    tick();
    chk("w0_ready_back", bus.cmd_ready, 1'b1);
    chk("w0_done_off", bus.done, 1'b0);

    // 5: ROTL len=7, reset asserted during step 3
    cmd(2'b10, 4'b0000, 3'd7);
    tick();
    bus.cmd_valid = 1'b0;
    chk("rr_M0", bus.M, 2'b10);
    tick();
    tick();
    chk("rr_M2", bus.M, 2'b10);
    chk("rr_q", q, 4'b1011);
    rst = 1'b0;
    #1;
    chk("rr_M_rst", bus.M, 2'b00);
    chk("rr_busy_rst", bus.busy, 1'b0);
    chk("rr_done_rst", bus.done, 1'b0);
    #3;
    rst = 1'b1;
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.done) n_done++;
    end
    chk("rr_no_done", 8'(n_done), 8'd0);
    chk("rr_ready", bus.cmd_ready, 1'b1);

    // 6: back-to-back LOAD 0001 then SHR len=5 data=1111, valid held
    cmd(2'b01, 4'b0001, 3'd0);
    tick();
    cmd(2'b11, 4'b1111, 3'd5);
    chk("bb_ld_M", bus.M, 2'b01);
    chk("bb_ld_D", bus.D, 4'b0001);
    chk("bb_ready1", bus.cmd_ready, 1'b0);
    tick();
    chk("bb_ld_done", bus.done, 1'b1);
    chk("bb_ready2", bus.cmd_ready, 1'b0);
    tick();
    chk("bb_ready3", bus.cmd_ready, 1'b1);
    chk("bb_q_ld", q, 4'b0001);
    tick();
    bus.cmd_valid = 1'b0;
    chk("bb_M0", bus.M, 2'b11);
    chk("bb_SI0", bus.SI, 1'b1);
    tick();
    chk("bb_SI1", bus.SI, 1'b1);
    tick();
    chk("bb_SI2", bus.SI, 1'b1);
    tick();
    chk("bb_SI3", bus.SI, 1'b1);
    tick();
    chk("bb_SI4", bus.SI, 1'b0);
    chk("bb_M4", bus.M, 2'b11);
    tick();
    chk("bb_done", bus.done, 1'b1);
    chk("bb_q", q, 4'b0111);
    tick();
    chk("bb_ready_end", bus.cmd_ready, 1'b1);
    chk("bb_busy_end", bus.busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
